// File: rtl/sdram_init_pkg.sv
// SDRAM power-up init sequencer: shared types.
// Commands are encoded as {cs,ras,cas,we}.
package sdram_init_pkg;

  localparam int CNT_W = 16;
  localparam int A10   = 10;

  typedef enum logic [3:0] {
    CMD_INHIBIT = 4'b1111,
    CMD_NOP     = 4'b0111,
    CMD_PRE     = 4'b0010,
    CMD_REF     = 4'b0001,
    CMD_LMR     = 4'b0000
  } cmd_e;

  typedef enum logic [3:0] {
    WAIT,
    PRE,
    TRP,
    REF1,
    RFC1,
    REF2,
    RFC2,
    LMR,
    MRD,
    DONE
  } state_e;

endpackage

// File: rtl/sdram_init_seq_counter.sv
// Loadable down-counter that saturates at zero.
// Reports zero while the held count is zero.
module sdram_delay_counter
  import sdram_init_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM init FSM: WAIT, PRECHARGE, 2x REFRESH, LOAD MODE.
// Outputs are registered decodes of the next state.
module sdram_init_seq
  import sdram_init_pkg::*;
#(
  parameter int          WAIT_CYCLES = 5000,
  parameter int          TRP_CYCLES  = 2,
  parameter int          TRFC_CYCLES = 4,
  parameter int          TMRD_CYCLES = 2,
  parameter logic [12:0] MODE_REG    = 13'h0033
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init_req,
  output logic        cke,
  output logic        cs,
  output logic        ras,
  output logic        cas,
  output logic        we,
  output logic [12:0] addr,
  output logic [1:0]  ba,
  output logic        init_done,
  output logic        busy
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 65535 ||
      TRP_CYCLES  < 1 || TRP_CYCLES  > 65535 ||
      TRFC_CYCLES < 1 || TRFC_CYCLES > 65535 ||
      TMRD_CYCLES < 1 || TMRD_CYCLES > 65535) begin : g_bad
    $fatal(1, "sdram_init_seq: *_CYCLES out of 1..65535");
  end

  localparam logic [CNT_W-1:0] WAIT_V = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TRP_V  = CNT_W'(TRP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TRFC_V = CNT_W'(TRFC_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMRD_V = CNT_W'(TMRD_CYCLES - 1);

  logic [1:0] sync_q, sync_d;
  logic       rst_n_s;

  assign sync_d = {sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rst_n_s = sync_q[1];

  state_e           state_q, state_d;
  cmd_e             cmd_q, cmd_d;
  logic             run_q, run_d;
  logic             cke_q, cke_d;
  logic [12:0]      addr_q, addr_d;
  logic [1:0]       ba_q, ba_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             zero;

  sdram_delay_counter #(
    .RST_VAL (WAIT_V)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n_s),
    .load     (load),
    .en       (run_q),
    .load_val (load_val),
    .zero     (zero)
  );

  // First edge after sync only starts the run; WAIT count is preloaded.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = '0;
    run_d    = 1'b1;
    if (run_q) begin
      unique case (state_q)
        WAIT: if (zero) state_d = PRE;
        PRE: begin
          state_d  = TRP;
          load     = 1'b1;
          load_val = TRP_V;
        end
        TRP: if (zero) state_d = REF1;
        REF1: begin
          state_d  = RFC1;
          load     = 1'b1;
          load_val = TRFC_V;
        end
        RFC1: if (zero) state_d = REF2;
        REF2: begin
          state_d  = RFC2;
          load     = 1'b1;
          load_val = TRFC_V;
        end
        RFC2: if (zero) state_d = LMR;
        LMR: begin
          state_d  = MRD;
          load     = 1'b1;
          load_val = TMRD_V;
        end
        MRD: if (zero) state_d = DONE;
        DONE: begin
          if (init_req) begin
            state_d  = WAIT;
            load     = 1'b1;
            load_val = WAIT_V;
          end
        end
        default: state_d = WAIT;
      endcase
    end
  end

  always_comb begin
    cke_d  = 1'b1;
    cmd_d  = CMD_NOP;
    addr_d = '0;
    ba_d   = '0;
    done_d = (state_d == DONE);
    busy_d = (state_d != DONE);
    unique case (1'b1)
      (state_d == PRE): begin
        cmd_d       = CMD_PRE;
        addr_d[A10] = 1'b1;
      end
      (state_d == REF1),
      (state_d == REF2): cmd_d = CMD_REF;
      (state_d == LMR): begin
        cmd_d  = CMD_LMR;
        addr_d = MODE_REG;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q <= WAIT;
      run_q   <= 1'b0;
      cke_q   <= 1'b0;
      cmd_q   <= CMD_INHIBIT;
      addr_q  <= '0;
      ba_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      cke_q   <= cke_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      ba_q    <= ba_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign cke             = cke_q;
  assign {cs,ras,cas,we} = cmd_q;
  assign addr            = addr_q;
  assign ba              = ba_q;
  assign init_done       = done_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_sdram_init_seq.sv
// Scoreboard bench for sdram_init_seq at default timings.
// Expected outputs come from cycle offsets of the command schedule.
module tb_sdram_init_seq;

  localparam int W    = 5000;
  localparam int TRP  = 2;
  localparam int TRFC = 4;
  localparam int TMRD = 2;
  localparam logic [12:0] MR = 13'h0033;

  localparam int P  = W;
  localparam int R1 = P + 1 + TRP;
  localparam int R2 = R1 + 1 + TRFC;
  localparam int L  = R2 + 1 + TRFC;
  localparam int D  = L + 1 + TMRD;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        init_req = 1'b0;
  logic        cke, cs, ras, cas, we;
  logic [12:0] addr;
  logic [1:0]  ba;
  logic        init_done, busy;

  sdram_init_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .init_req  (init_req),
    .cke       (cke),
    .cs        (cs),
    .ras       (ras),
    .cas       (cas),
    .we        (we),
    .addr      (addr),
    .ba        (ba),
    .init_done (init_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cke;
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic [1:0]  ba;
    logic        done;
    logic        busy;
    bit          first_done;
    int          t;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   t = -1;
  int   pre = 2;
  int   ref_cnt = 0;
  int   printed = 0;

  function automatic exp_t model(int tt);
    exp_t e;
    e.t = tt;
    e.first_done = (tt == D);
    e.ba = 2'b00;
    e.addr = 13'h0000;
    if (tt < 0) begin
      e.cke = 1'b0; e.cmd = 4'b1111;
      e.done = 1'b0; e.busy = 1'b0;
      return e;
    end
    e.cke = 1'b1;
    e.cmd = 4'b0111;
    e.done = (tt >= D);
    e.busy = (tt < D);
    if (tt == P) begin
      e.cmd = 4'b0010; e.addr = 13'h0400;
    end else if (tt == R1 || tt == R2) begin
      e.cmd = 4'b0001;
    end else if (tt == L) begin
      e.cmd = 4'b0000; e.addr = MR;
    end
    return e;
  endfunction

  task automatic tick();
    logic r;
    exp_t e;
    @(posedge clk);
    r = init_req;
    if (!reset_n) begin
      t = -1; pre = 2;
    end else if (pre > 0) begin
      pre--;
    end else if (t < 0) begin
      t = 0;
    end else if (t >= D && r) begin
      t = 0;
    end else begin
      t++;
    end
    e = model(pre > 0 || !reset_n ? -1 : t);
    #1 q.push_back(e);
  endtask

  task automatic run_until(int target, bit rnd);
    int k;
    for (k = 0; k < 20000 && t != target; k++) begin
      tick();
      init_req = rnd && t >= 0 && t < D &&
                 ($urandom_range(0, 299) == 0);
    end
    init_req = 1'b0;
    checks++;
    if (t != target) begin
      failures++;
      $display("FAIL run_until: reached t=%0d, need %0d", t, target);
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  exp_t m;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      m = q.pop_front();
      checks++;
      if ({cke, cs, ras, cas, we, addr, ba, init_done, busy} !==
          {m.cke, m.cmd, m.addr, m.ba, m.done, m.busy}) begin
        failures++;
        if (printed < 30) begin
          printed++;
          $display("FAIL cyc t=%0d: got cke=%b cmd=%b%b%b%b a=%h ba=%0d dn=%b bz=%b want cke=%b cmd=%b a=%h ba=%0d dn=%b bz=%b",
                   m.t, cke, cs, ras, cas, we, addr, ba, init_done, busy,
                   m.cke, m.cmd, m.addr, m.ba, m.done, m.busy);
        end
      end
      if ({cs, ras, cas, we} == 4'b0001) ref_cnt++;
      if ({cs, ras, cas, we} == 4'b0010) ref_cnt = 0;
      if (m.first_done) begin
        checks++;
        if (ref_cnt != 2) begin
          failures++;
          $display("FAIL ref_count: got %0d want 2", ref_cnt);
        end
      end
    end
  end

  initial begin
    int gap;
    repeat (3) tick();
    @(negedge clk); #1 reset_n = 1'b1;
    for (int k = 0; k < 20000 && t != 6000; k++) begin
      tick();
      init_req = (t == 100) || (t == 6000) ||
                 (t >= 0 && t < D && $urandom_range(0, 299) == 0);
    end
    chk("reach_6000", t, 6000);
    tick();
    init_req = 1'b0;
    chk("restart_t", t, 0);
    gap = D + $urandom_range(5, 40);
    run_until(gap, 1'b1);
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    run_until(3000, 1'b1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_cke", cke, 0);
    chk("rst_cmd", {cs, ras, cas, we}, 4'b1111);
    chk("rst_addr", addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", init_done, 0);
    repeat (3) tick();
    @(negedge clk); #1 reset_n = 1'b1;
    run_until(D + 10, 1'b1);
    repeat (3) @(negedge clk);
    chk("q_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
